// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: retires R multiplier bits per RUN cycle and
// returns a full 2N-bit product, signed or unsigned per transaction.
module seq_multiplier #(
  parameter int N = 8,
  parameter int R = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   p,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | accumulating R partial products per cycle
  // DONE  | product held on p until out_ready

  localparam int STEPS = N / R;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*N-1:0] acc;
  logic [2*N-1:0] a_sh;
  logic [2*N-1:0] sum;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           last;

  // Magnitude of -2^(N-1) wraps to 2^(N-1), which still fits in N unsigned bits.
  assign mag_a = (is_signed && a[N-1]) ? -a : a;
  assign mag_b = (is_signed && b[N-1]) ? -b : b;
  assign last  = (cnt == LAST);

  // a_sh tracks mag_a << (cnt*R), so each term only needs a fixed shift by j.
  always_comb begin
    sum = acc;
    for (int j = 0; j < R; j++) begin
      if (b_reg[j]) sum = sum + (a_sh << j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      a_sh  <= '0;
      b_reg <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            cnt   <= '0;
            a_sh  <= {{N{1'b0}}, mag_a};
            b_reg <= mag_b;
            neg   <= is_signed & (a[N-1] ^ b[N-1]);
          end
        end
        RUN: begin
          acc   <= sum;
          a_sh  <= a_sh << R;
          b_reg <= b_reg >> R;
          cnt   <= cnt + CW'(1);
          if (last) p <= neg ? -sum : sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: N=8 at R=1/2/8 plus N=6 R=3, directed table,
// backpressure and reset corners, and random pairs against an arithmetic model.
module tb_seq_multiplier;

  logic clk;
  logic rst_n;

  logic        in_valid_v [4];
  logic        in_ready_v [4];
  logic [7:0]  a_v        [4];
  logic [7:0]  b_v        [4];
  logic        signed_v   [4];
  logic        out_valid_v[4];
  logic        out_ready_v[4];
  logic [15:0] p_v        [4];
  logic        busy_v     [4];
  logic [11:0] p6;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g8
    localparam int RG = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    seq_multiplier #(.N(8), .R(RG)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
      .a(a_v[g]), .b(b_v[g]), .is_signed(signed_v[g]),
      .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
      .p(p_v[g]), .busy(busy_v[g])
    );
  end

  seq_multiplier #(.N(6), .R(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a_v[3][5:0]), .b(b_v[3][5:0]), .is_signed(signed_v[3]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .p(p6), .busy(busy_v[3])
  );
  assign p_v[3] = {4'b0000, p6};

  function automatic longint ref_mul(longint av, longint bv, bit s, int n);
    longint x = av;
    longint y = bv;
    longint full = longint'(1) << n;
    if (s) begin
      if (x >= (full >> 1)) x = x - full;
      if (y >= (full >> 1)) y = y - full;
    end
    return (x * y) & ((longint'(1) << (2 * n)) - 1);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction with out_ready high; checks latency, product and handoff.
  task automatic run(input int g, input int av, input int bv, input bit s,
                     input longint exp, input int exp_lat, input string name);
    int k;
    int lat;
    logic [15:0] held;
    out_ready_v[g] = 1'b1;
    @(negedge clk);
    k = 0;
    while (!in_ready_v[g] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk({name, "_ready_timeout"}, 0, 1);
    in_valid_v[g] = 1'b1;
    a_v[g] = 8'(av);
    b_v[g] = 8'(bv);
    signed_v[g] = s;
    @(posedge clk);
    #1 in_valid_v[g] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid_v[g] && lat < 40);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_p"}, p_v[g], exp);
    held = p_v[g];
    @(posedge clk);
    #1;
    chk({name, "_handoff_ready_valid"}, {in_ready_v[g], out_valid_v[g]}, 2'b10);
    chk({name, "_p_hold"}, p_v[g], held);
  endtask

  typedef struct {
    int      av;
    int      bv;
    bit      s;
    longint  exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ok;
    checks = 0;
    failures = 0;
    for (int g = 0; g < 4; g++) begin
      in_valid_v[g] = 1'b0;
      a_v[g] = '0;
      b_v[g] = '0;
      signed_v[g] = 1'b0;
      out_ready_v[g] = 1'b1;
    end

    vecs[0] = '{255,  255,  1'b0, 64'hFE01};
    vecs[1] = '{'h80, 'h80, 1'b1, 64'h4000};
    vecs[2] = '{'h80, 'h7F, 1'b1, 64'hC080};
    vecs[3] = '{'hFF, 3,    1'b1, 64'hFFFD};
    vecs[4] = '{0,    'hFF, 1'b0, 64'h0000};
    vecs[5] = '{1,    'hFF, 1'b0, 64'h00FF};
    vecs[6] = '{1,    'hFF, 1'b1, 64'hFFFF};
    vecs[7] = '{0,    'hFF, 1'b1, 64'h0000};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid_v[0], 0);
    chk("reset_busy", busy_v[0], 0);
    chk("reset_in_ready", in_ready_v[0], 1);
    chk("reset_p", p_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(0, vecs[i].av, vecs[i].bv, vecs[i].s, vecs[i].exp, 8, $sformatf("vec%0d", i));

    run(1, 13, 11, 1'b0, 143, 4, "r2_13x11");
    run(2, 13, 11, 1'b0, 143, 1, "r8_13x11");

    // Backpressure: new operands presented while the product is held.
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    a_v[0] = 8'd13;
    b_v[0] = 8'd11;
    signed_v[0] = 1'b0;
    @(posedge clk);
    #1;
    a_v[0] = 8'd7;
    b_v[0] = 8'd9;
    ok = 0;
    for (int c = 0; c < 40 && !out_valid_v[0]; c++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid_rise", out_valid_v[0], 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {out_valid_v[0], in_ready_v[0], p_v[0]}, {1'b1, 1'b0, 16'd143});
    end
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_release", {in_ready_v[0], out_valid_v[0]}, 2'b10);
    run(0, 7, 9, 1'b0, 63, 8, "bp_next");

    // Asynchronous reset three cycles into RUN.
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    a_v[0] = 8'd200;
    b_v[0] = 8'd100;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_run_state", {out_valid_v[0], busy_v[0], in_ready_v[0]}, 3'b001);
    chk("rst_mid_run_p", p_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 7, 6, 1'b0, 42, 8, "after_rst");

    for (int i = 0; i < 200; i++) begin
      int ra = $urandom_range(0, 255);
      int rb = $urandom_range(0, 255);
      bit rs = 1'($urandom_range(0, 1));
      run(1 + (i % 2), ra, rb, rs, ref_mul(ra, rb, rs, 8), (i % 2 == 0) ? 4 : 1, "rand8");
    end

    for (int i = 0; i < 10000; i++) begin
      int ra = $urandom_range(0, 63);
      int rb = $urandom_range(0, 63);
      bit rs = 1'($urandom_range(0, 1));
      run(3, ra, rb, rs, ref_mul(ra, rb, rs, 6), 2, "rand6");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
